integrator_sample_frontend: RTL and testbench
=============================================

Name: integrator_sample_frontend

Overview:
- Upstream stage of the TinyQV integrator peripheral. Produces the single-cycle sample_strobe / sample_in pair that the integrator core consumes.
- Two sample sources:
  - External: PMOD strobe/data pins, synchronised and rising-edge detected.
  - Internal: register writes, or a programmable periodic timer.
- Samples are buffered in a small FIFO so that bursts are not lost. Drops are counted and flagged.

Parameters:
- IN_W, 8, width of sample_out. External 6-bit data is zero-extended to this width.
- FIFO_DEPTH, 4, sample buffer entries. Must be a power of two and >= 2.
- SYNC_STAGES, 2, synchroniser flops on ext_strobe, ext_enable and ext_data. Must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ext_strobe  in  1  external sample strobe pin (asynchronous)
- ext_enable  in  1  external enable pin (asynchronous)
- ext_data  in  6  external sample data pins (asynchronous)
- mode_ext  in  1  1 = external source, 0 = internal source
- reg_enable  in  1  integrator enable used in internal mode
- reg_sample  in  IN_W  internal sample value
- reg_write  in  1  one-cycle pulse: CPU wrote the input register
- timer_enable  in  1  periodic internal sampling on/off
- timer_period  in  8  tick every timer_period+1 cycles
- out_ready  in  1  downstream may accept a sample; tie high for the integrator core
- flush  in  1  synchronous clear of FIFO and prescaler
- clear_flags  in  1  clears overrun and drop_count
- sample_strobe  out  1  one-cycle sample valid to integrator
- sample_out  out  IN_W  sample data; valid while sample_strobe is high
- enable_out  out  1  integrator enable
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overrun  out  1  sticky: at least one sample was dropped
- drop_count  out  8  saturating count of dropped samples

Behaviour:
- Reset values: all outputs 0, FIFO empty, prescaler 0, synchroniser and edge-detect flops 0.
- Synchronisation: ext_* pass through SYNC_STAGES flops. The edge detector compares the synced strobe against its previous value.
- External event: synced strobe rising edge while mode_ext=1. Captured data is the synced ext_data from the same cycle, zero-extended to IN_W.
- Internal event (mode_ext=0) fires on either condition; simultaneous conditions produce one push only:
  - reg_write=1 → pushes reg_sample.
  - Timer tick → pushes reg_sample.
- Prescaler behaviour:
  - Counts only while timer_enable=1 and mode_ext=0.
  - Tick when count == timer_period; count then returns to 0.
  - timer_period=0 → tick every cycle.
  - timer_enable low → count held at 0.
- Each event produces exactly one FIFO push attempt.
- Pop: FIFO non-empty and out_ready=1. Popped data is registered into sample_out with sample_strobe=1 for exactly one cycle. Otherwise sample_strobe=0 and sample_out holds its last value.
- Latency:
  - Event in cycle t (FIFO previously empty, out_ready=1) → sample_strobe high in cycle t+2.
  - ext_strobe pin rise → strobe after SYNC_STAGES+2 cycles.
- Throughput: one sample per cycle maximum.
- Full FIFO, push without pop:
  - New sample dropped; FIFO contents unchanged.
  - overrun set.
  - drop_count increments, saturating at 255.
- Full FIFO with simultaneous push and pop: both succeed, level unchanged, no drop.
- Empty FIFO: no pop, no strobe. Pointers wrap modulo FIFO_DEPTH.
- flush or any change of mode_ext (detected against a registered copy) in cycle t:
  - FIFO emptied and prescaler zeroed at the end of t.
  - A push in cycle t is discarded and not counted as a drop.
  - A pop in cycle t is still allowed.
- Edge detector on a mode_ext change: previous-strobe flop loads the current synced strobe, so no false edge.
- clear_flags: clears overrun and drop_count. If a drop occurs in the same cycle, overrun=1 and drop_count=1.
- enable_out, registered: mode_ext ? synced ext_enable : reg_enable. One cycle of delay.
- Reset asserted mid-operation: immediate return to reset values; no strobe emitted.

Test Plan:
- Internal, timer_enable=1, timer_period=3, reg_sample=0x25, out_ready=1 → sample_strobe every 4 cycles with sample_out=0x25; fifo_level never exceeds 1.
- Internal, out_ready=0, six reg_write pulses with values 1..6 → fifo_level=4, overrun=1, drop_count=2. Then out_ready=1 → strobes output 1,2,3,4 on consecutive cycles.
- External, ext_data=0x3F held, ext_strobe 0→1 → exactly one strobe with sample_out=0x3F, SYNC_STAGES+2 cycles after the pin edge. Strobe held high for 10 cycles → no further strobes.
- FIFO full, out_ready=1, push in the same cycle → no drop, level stays 4. clear_flags coincident with a drop → overrun=1, drop_count=1.
- FIFO holding 3 entries, mode_ext toggled → fifo_level=0 the next cycle, no strobes. ext_strobe already high at the switch → no spurious event.
- rst_n pulled low while FIFO holds 2 entries → all outputs 0 immediately. After release, no strobe until a new event.

Source files
------------

// File: rtl/integrator_sample_frontend.sv
// integrator_sample_frontend
//
// Upstream stage of the integrator peripheral. Collects samples from either the
// external PMOD pins (synchronised, rising-edge detected strobe) or from the
// internal source (CPU register writes and a programmable periodic timer),
// buffers them in a small FIFO and hands them to the integrator core as a
// single-cycle sample_strobe / sample_out pair. Samples that find the FIFO full
// are dropped, counted (saturating) and flagged with a sticky overrun bit.
//
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   ext_strobe/enable/data external pins (asynchronous to clk)
//   mode_ext               1 = external source, 0 = internal source
//   reg_enable             integrator enable used in internal mode
//   reg_sample, reg_write  internal sample value and its write pulse
//   timer_enable/period    periodic internal sampling, tick every period+1 cycles
//   out_ready              downstream may accept a sample
//   flush                  synchronous clear of FIFO and prescaler
//   clear_flags            clears overrun and drop_count
//   sample_strobe/out      one-cycle sample valid and its data
//   enable_out             registered integrator enable
//   fifo_level             current FIFO occupancy
//   overrun, drop_count    sticky drop flag and saturating drop counter

module integrator_sample_frontend #(
    parameter int IN_W        = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ext_strobe,
    input  logic                          ext_enable,
    input  logic [5:0]                    ext_data,
    input  logic                          mode_ext,
    input  logic                          reg_enable,
    input  logic [IN_W-1:0]               reg_sample,
    input  logic                          reg_write,
    input  logic                          timer_enable,
    input  logic [7:0]                    timer_period,
    input  logic                          out_ready,
    input  logic                          flush,
    input  logic                          clear_flags,
    output logic                          sample_strobe,
    output logic [IN_W-1:0]               sample_out,
    output logic                          enable_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    output logic [7:0]                    drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [SYNC_STAGES-1:0]      strobe_sync_q, strobe_sync_d;
    logic [SYNC_STAGES-1:0]      enable_sync_q, enable_sync_d;
    logic [SYNC_STAGES-1:0][5:0] data_sync_q, data_sync_d;
    logic                        strobe_prev_q, strobe_prev_d;
    logic                        mode_q, mode_d;
    logic [7:0]                  presc_q, presc_d;
    logic [IN_W-1:0]             mem_q [FIFO_DEPTH];
    logic [IN_W-1:0]             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]            level_q, level_d;
    logic                        sample_strobe_q, sample_strobe_d;
    logic [IN_W-1:0]             sample_out_q, sample_out_d;
    logic                        enable_out_q, enable_out_d;
    logic                        overrun_q, overrun_d;
    logic [7:0]                  drop_count_q, drop_count_d;

    logic            strobe_s, enable_s;
    logic [5:0]      data_s;
    logic            clr, timer_run, tick, push, pop, push_ok, drop, full;
    logic [IN_W-1:0] push_data;

    assign strobe_s = strobe_sync_q[SYNC_STAGES-1];
    assign enable_s = enable_sync_q[SYNC_STAGES-1];
    assign data_s   = data_sync_q[SYNC_STAGES-1];

    always_comb begin
        strobe_sync_d = {strobe_sync_q[SYNC_STAGES-2:0], ext_strobe};
        enable_sync_d = {enable_sync_q[SYNC_STAGES-2:0], ext_enable};
        data_sync_d   = data_sync_q;
        data_sync_d[0] = ext_data;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            data_sync_d[i] = data_sync_q[i-1];
        end

        // Tracking the synced strobe every cycle also covers a mode switch:
        // a strobe already high when entering external mode is not an edge.
        strobe_prev_d = strobe_s;
        mode_d        = mode_ext;

        // A source switch invalidates whatever was queued from the old source.
        clr = flush | (mode_ext != mode_q);

        timer_run = timer_enable & ~mode_ext;
        tick      = timer_run & (presc_q == timer_period);
        if (clr || !timer_run || tick) begin
            presc_d = 8'd0;
        end else begin
            presc_d = presc_q + 8'd1;
        end

        push      = mode_ext ? (strobe_s & ~strobe_prev_q) : (reg_write | tick);
        push_data = mode_ext ? IN_W'(data_s) : reg_sample;

        full    = (level_q == LVL_W'(FIFO_DEPTH));
        pop     = (level_q != '0) & out_ready;
        push_ok = push & ~clr & (~full | pop);
        drop    = push & ~clr & full & ~pop;

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
        end

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop);
        end

        sample_strobe_d = pop;
        sample_out_d    = pop ? mem_q[rd_ptr_q] : sample_out_q;
        enable_out_d    = mode_ext ? enable_s : reg_enable;

        if (clear_flags) begin
            overrun_d    = drop;
            drop_count_d = {7'd0, drop};
        end else begin
            overrun_d    = overrun_q | drop;
            drop_count_d = (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_sync_q   <= '0;
            enable_sync_q   <= '0;
            data_sync_q     <= '0;
            strobe_prev_q   <= 1'b0;
            mode_q          <= 1'b0;
            presc_q         <= 8'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            sample_strobe_q <= 1'b0;
            sample_out_q    <= '0;
            enable_out_q    <= 1'b0;
            overrun_q       <= 1'b0;
            drop_count_q    <= 8'd0;
        end else begin
            strobe_sync_q   <= strobe_sync_d;
            enable_sync_q   <= enable_sync_d;
            data_sync_q     <= data_sync_d;
            strobe_prev_q   <= strobe_prev_d;
            mode_q          <= mode_d;
            presc_q         <= presc_d;
            mem_q           <= mem_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            sample_strobe_q <= sample_strobe_d;
            sample_out_q    <= sample_out_d;
            enable_out_q    <= enable_out_d;
            overrun_q       <= overrun_d;
            drop_count_q    <= drop_count_d;
        end
    end

    assign sample_strobe = sample_strobe_q;
    assign sample_out    = sample_out_q;
    assign enable_out    = enable_out_q;
    assign fifo_level    = level_q;
    assign overrun       = overrun_q;
    assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_integrator_sample_frontend.sv
// Bench for integrator_sample_frontend: directed scenarios followed by random
// stimulus, every cycle compared against a queue-based reference model.

module tb_integrator_sample_frontend;

    localparam int IN_W  = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     ext_strobe = 1'b0;
    logic                     ext_enable = 1'b0;
    logic [5:0]               ext_data = '0;
    logic                     mode_ext = 1'b0;
    logic                     reg_enable = 1'b0;
    logic [IN_W-1:0]          reg_sample = '0;
    logic                     reg_write = 1'b0;
    logic                     timer_enable = 1'b0;
    logic [7:0]               timer_period = '0;
    logic                     out_ready = 1'b0;
    logic                     flush = 1'b0;
    logic                     clear_flags = 1'b0;
    logic                     sample_strobe;
    logic [IN_W-1:0]          sample_out;
    logic                     enable_out;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic                     overrun;
    logic [7:0]               drop_count;

    integrator_sample_frontend #(
        .IN_W(IN_W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ext_strobe(ext_strobe), .ext_enable(ext_enable), .ext_data(ext_data),
        .mode_ext(mode_ext), .reg_enable(reg_enable), .reg_sample(reg_sample),
        .reg_write(reg_write), .timer_enable(timer_enable), .timer_period(timer_period),
        .out_ready(out_ready), .flush(flush), .clear_flags(clear_flags),
        .sample_strobe(sample_strobe), .sample_out(sample_out), .enable_out(enable_out),
        .fifo_level(fifo_level), .overrun(overrun), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: sample buffer as a queue, pins delayed through arrays.
    int mq[$];
    int m_out, m_stb, m_ov, m_dc, m_en, m_cnt, m_mode, m_prev;
    int m_ss[SYNC];
    int m_se[SYNC];
    int m_sd[SYNC];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out = 0; m_stb = 0; m_ov = 0; m_dc = 0; m_en = 0;
        m_cnt = 0; m_mode = 0; m_prev = 0;
        for (int i = 0; i < SYNC; i++) begin
            m_ss[i] = 0; m_se[i] = 0; m_sd[i] = 0;
        end
    endtask

    task automatic model_step();
        int s_str, s_en, s_dat, clr, tick, ev, val, pop, drop, size0;
        s_str = m_ss[SYNC-1];
        s_en  = m_se[SYNC-1];
        s_dat = m_sd[SYNC-1];
        clr   = (flush || (int'(mode_ext) != m_mode)) ? 1 : 0;
        tick  = (!mode_ext && timer_enable && m_cnt == int'(timer_period)) ? 1 : 0;
        if (mode_ext) begin
            ev  = (s_str == 1 && m_prev == 0) ? 1 : 0;
            val = s_dat;
        end else begin
            ev  = (reg_write || tick) ? 1 : 0;
            val = int'(reg_sample);
        end
        size0 = mq.size();
        pop   = (size0 > 0 && out_ready) ? 1 : 0;
        m_stb = pop;
        if (pop == 1) m_out = mq.pop_front();
        drop = 0;
        if (ev == 1 && clr == 0) begin
            if (size0 < DEPTH || pop == 1) mq.push_back(val);
            else drop = 1;
        end
        if (clr == 1) mq.delete();
        if (clear_flags) begin
            m_ov = drop; m_dc = drop;
        end else begin
            if (drop == 1) m_ov = 1;
            if (drop == 1 && m_dc < 255) m_dc++;
        end
        if (clr == 1 || !(timer_enable && !mode_ext) || tick == 1) m_cnt = 0;
        else m_cnt++;
        m_en   = mode_ext ? s_en : int'(reg_enable);
        m_prev = s_str;
        m_mode = int'(mode_ext);
        for (int i = SYNC - 1; i > 0; i--) begin
            m_ss[i] = m_ss[i-1]; m_se[i] = m_se[i-1]; m_sd[i] = m_sd[i-1];
        end
        m_ss[0] = int'(ext_strobe);
        m_se[0] = int'(ext_enable);
        m_sd[0] = int'(ext_data);
    endtask

    task automatic check_all(string ph);
        chk({ph, ".strobe"},  32'(sample_strobe), 32'(m_stb));
        chk({ph, ".out"},     32'(sample_out),    32'(m_out));
        chk({ph, ".enable"},  32'(enable_out),    32'(m_en));
        chk({ph, ".level"},   32'(fifo_level),    32'(mq.size()));
        chk({ph, ".overrun"}, 32'(overrun),       32'(m_ov));
        chk({ph, ".drops"},   32'(drop_count),    32'(m_dc));
    endtask

    task automatic cycle(string ph);
        @(posedge clk);
        model_step();
        #1;
        check_all(ph);
    endtask

    task automatic check_zero(string ph);
        chk({ph, ".strobe0"}, 32'(sample_strobe), 32'd0);
        chk({ph, ".out0"},    32'(sample_out),    32'd0);
        chk({ph, ".en0"},     32'(enable_out),    32'd0);
        chk({ph, ".level0"},  32'(fifo_level),    32'd0);
        chk({ph, ".ov0"},     32'(overrun),       32'd0);
        chk({ph, ".dc0"},     32'(drop_count),    32'd0);
    endtask

    initial begin
        int n;
        int got[$];

        // Reset
        model_reset();
        #3;
        check_zero("reset");
        #10;
        rst_n = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) cycle("idle");

        // Timer-driven internal sampling, period 3
        reg_sample = 8'h25; timer_period = 8'd3; timer_enable = 1'b1; out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle("timer");
            chk("timer.level_le1", 32'(fifo_level <= 1), 32'd1);
            if (sample_strobe) begin
                n++;
                chk("timer.value", 32'(sample_out), 32'h25);
            end
        end
        chk("timer.strobe_count", 32'(n), 32'd9);
        timer_enable = 1'b0;
        for (int i = 0; i < 4; i++) cycle("drain1");

        // Burst into a stalled FIFO
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            reg_sample = 8'(i); reg_write = 1'b1;
            cycle("burst");
        end
        reg_write = 1'b0;
        chk("burst.level", 32'(fifo_level), 32'd4);
        chk("burst.overrun", 32'(overrun), 32'd1);
        chk("burst.drops", 32'(drop_count), 32'd2);
        out_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 6; i++) begin
            cycle("release");
            if (i < 4) chk("release.consecutive", 32'(sample_strobe), 32'd1);
            if (sample_strobe) got.push_back(int'(sample_out));
        end
        chk("release.count", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("release.order", 32'(got[i]), 32'(i + 1));

        // Full FIFO: simultaneous push/pop, then clear_flags with a drop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            reg_sample = 8'(8'h10 + i); reg_write = 1'b1;
            cycle("fill");
        end
        out_ready = 1'b1; reg_sample = 8'h14;
        cycle("full_pushpop");
        chk("full_pushpop.level", 32'(fifo_level), 32'd4);
        chk("full_pushpop.drops", 32'(drop_count), 32'd2);
        out_ready = 1'b0; reg_sample = 8'h15; clear_flags = 1'b1;
        cycle("clear_drop");
        chk("clear_drop.overrun", 32'(overrun), 32'd1);
        chk("clear_drop.drops", 32'(drop_count), 32'd1);
        clear_flags = 1'b0; reg_write = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle("drain2");

        // External edge latency and held strobe
        mode_ext = 1'b1; ext_data = 6'h3F; ext_strobe = 1'b0; ext_enable = 1'b1;
        for (int i = 0; i < 5; i++) cycle("ext_setup");
        ext_strobe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("ext_lat");
            chk("ext_lat.early", 32'(sample_strobe), 32'd0);
        end
        cycle("ext_hit");
        chk("ext_hit.strobe", 32'(sample_strobe), 32'd1);
        chk("ext_hit.value", 32'(sample_out), 32'h3F);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle("ext_hold");
            if (sample_strobe) n++;
        end
        chk("ext_hold.no_more", 32'(n), 32'd0);

        // Mode switch with 3 queued entries and the strobe pin already high
        mode_ext = 1'b0; out_ready = 1'b0;
        cycle("to_int");
        for (int i = 0; i < 3; i++) begin
            reg_sample = 8'(8'h30 + i); reg_write = 1'b1;
            cycle("fill3");
        end
        reg_write = 1'b0;
        chk("fill3.level", 32'(fifo_level), 32'd3);
        mode_ext = 1'b1;
        cycle("switch");
        chk("switch.level", 32'(fifo_level), 32'd0);
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cycle("after_switch");
            if (sample_strobe) n++;
        end
        chk("after_switch.no_strobe", 32'(n), 32'd0);

        // Reset in the middle of operation
        mode_ext = 1'b0; out_ready = 1'b0;
        cycle("to_int2");
        for (int i = 0; i < 2; i++) begin
            reg_sample = 8'(8'h40 + i); reg_write = 1'b1;
            cycle("fill2");
        end
        reg_write = 1'b0; reg_enable = 1'b1;
        cycle("fill2_idle");
        chk("fill2.level", 32'(fifo_level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        model_reset();
        #3;
        rst_n = 1'b1;
        reg_enable = 1'b0; out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            cycle("post_reset");
            if (sample_strobe) n++;
        end
        chk("post_reset.no_strobe", 32'(n), 32'd0);

        // Drop counter saturation
        out_ready = 1'b0; reg_write = 1'b1; reg_sample = 8'h55;
        for (int i = 0; i < 265; i++) cycle("saturate");
        chk("saturate.drops", 32'(drop_count), 32'd255);
        reg_write = 1'b0; clear_flags = 1'b1;
        cycle("sat_clear");
        chk("sat_clear.drops", 32'(drop_count), 32'd0);
        clear_flags = 1'b0; out_ready = 1'b1;

        // Random traffic
        timer_period = 8'd2;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(2) == 0) ext_strobe = ~ext_strobe;
            ext_data   = 6'($urandom);
            ext_enable = 1'($urandom);
            if ($urandom_range(29) == 0) mode_ext = ~mode_ext;
            reg_enable = 1'($urandom);
            reg_sample = 8'($urandom);
            reg_write  = ($urandom_range(2) == 0);
            if ($urandom_range(19) == 0) timer_enable = ~timer_enable;
            if ($urandom_range(19) == 0) timer_period = 8'($urandom_range(4));
            out_ready   = ($urandom_range(9) < 7);
            flush       = ($urandom_range(24) == 0);
            clear_flags = ($urandom_range(24) == 0);
            cycle("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
